// File: rtl/dmem_access_ctrl.sv
// Arbiter and fixed-latency sequencer for the shared single-ported datamem.
// CPU (MEM stage) has priority; DMA is forced after STARVE_MAX CPU grants.
module dmem_access_ctrl #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [63:0] dma_addr,
    input  logic [63:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [63:0] dma_rdata,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SL = $clog2(STARVE_MAX + 1);
    localparam int SW = (SL > 3) ? SL : 3;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        CPU_BUSY,
        DMA_BUSY
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic          we_q;
    logic [63:0]   addr_q, wdata_q;
    logic [63:0]   cpu_rdata_q, dma_rdata_q;
    logic          grant_cpu, grant_dma;
    logic          busy, last, cpu_fin, dma_fin;

    assign busy    = (state != IDLE);
    assign last    = busy && (cnt == CNT_LAST);
    assign cpu_fin = (state == CPU_BUSY) && last;
    assign dma_fin = (state == DMA_BUSY) && last;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        starve_nx = starve_cnt;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (dma_req && starve_cnt == STARVE_TOP)
                    grant_dma = 1'b1;
                else if (cpu_req)
                    grant_cpu = 1'b1;
                else if (dma_req)
                    grant_dma = 1'b1;
                if (grant_dma) begin
                    state_nx  = DMA_BUSY;
                    starve_nx = '0;
                end else if (grant_cpu) begin
                    state_nx = CPU_BUSY;
                    if (!dma_req)
                        starve_nx = '0;
                    else if (starve_cnt != STARVE_TOP)
                        starve_nx = starve_cnt + SW'(1);
                end else begin
                    starve_nx = '0;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                if (last) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            starve_cnt <= starve_nx;
        end
    end

    // Winner's fields are frozen for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_dma) begin
            we_q    <= dma_we;
            addr_q  <= dma_addr;
            wdata_q <= dma_wdata;
        end else if (grant_cpu) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_fin)
                cpu_rdata_q <= mem_read_data;
            if (dma_fin)
                dma_rdata_q <= mem_read_data;
        end
    end

    assign mem_address      = busy ? addr_q : '0;
    assign mem_write_data   = busy ? wdata_q : '0;
    assign mem_read_enable  = busy && !we_q;
    assign mem_write_enable = last && we_q;
    assign mem_xfer_size    = 4'd8;

    assign cpu_stall = cpu_req && !cpu_fin;
    assign cpu_rdata = cpu_fin ? mem_read_data : cpu_rdata_q;
    assign dma_gnt   = (state == DMA_BUSY);
    assign dma_done  = dma_fin;
    assign dma_rdata = dma_fin ? mem_read_data : dma_rdata_q;

endmodule
